mac_tx_frame_src: RTL

- Store-and-forward frame source feeding the MAC transmit stream (mac_tx_data/valid/sof/eof) of the RGMII MAC.
- Accepts bytes from upstream with a ready/valid/last handshake, which may stall. Buffers each whole frame so the MAC sees a gap-free valid burst.
- Pads short frames to the Ethernet minimum. Drops oversize frames.
- Enforces the eof-to-sof spacing the MAC needs for its FCS tail plus inter-packet gap.

---
 rtl/mac_pkg.sv | 34 +++
 rtl/mac_tx_fifo_ram.sv | 34 +++
 rtl/mac_tx_frame_src.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared constants and state types for the MAC transmit
//               frame source.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    // Ethernet framing limits in bytes, excluding FCS
    localparam int ETH_MIN_LEN      = 60;
    localparam int ETH_MAX_LEN      = 1514;

    // MAC appends a 4-byte FCS and needs a 13-cycle tail after eof,
    // followed by the 12-byte inter-packet gap.
    localparam int MAC_FCS_TAIL_CYC = 13;
    localparam int ETH_IPG_BYTES    = 12;

    // Read-side (MAC facing) state machine
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        PAD  = 2'd2,
        GAP  = 2'd3
    } tx_state_t;

    // Write-side (upstream facing) state
    typedef enum logic {
        ACCEPT  = 1'b0,
        DISCARD = 1'b1
    } wr_state_t;

endpackage : mac_pkg
`default_nettype wire

// File: rtl/mac_tx_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : mac_tx_fifo_ram
// Description : Simple dual-port byte RAM, one write port, one read port
//               with a registered (1-cycle) read.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_tx_fifo_ram #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [0:(1<<ADDR_W)-1];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: reads every cycle, data appears the cycle after the address
    always_ff @(posedge clk) begin
        o_rdata <= r_mem[i_raddr];
    end

endmodule : mac_tx_fifo_ram
`default_nettype wire

// File: rtl/mac_tx_frame_src.sv
`default_nettype none
// ============================================================================
// Module      : mac_tx_frame_src
// Description : Store-and-forward frame source for the MAC transmit stream.
//               Buffers whole frames, pads short ones to the minimum
//               length, drops oversize ones and spaces frames for the
//               FCS tail plus inter-packet gap.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_tx_frame_src
    import mac_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int LEN_W   = 3,
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int MAX_LEN = ETH_MAX_LEN,
    parameter int GAP_CYC = MAC_FCS_TAIL_CYC + ETH_IPG_BYTES
) (
    input  logic        mac_tx_clk,
    input  logic        mac_tx_rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  mac_tx_data,
    output logic        mac_tx_valid,
    output logic        mac_tx_sof,
    output logic        mac_tx_eof,
    output logic        busy,
    output logic [15:0] stat_sent,
    output logic [15:0] stat_dropped
);

    localparam logic [ADDR_W-1:0] c_MAX_LEN  = ADDR_W'(MAX_LEN);
    localparam logic [ADDR_W-1:0] c_MIN_LEN  = ADDR_W'(MIN_LEN);
    localparam logic [ADDR_W-1:0] c_PAD_LAST = ADDR_W'(MIN_LEN - 1);
    localparam int                c_GAP_W    = $clog2(GAP_CYC + 1);
    // eof->sof spans GAP_CYC cycles: the eof cycle, GAP_CYC-2 cycles in GAP
    // and the IDLE cycle that issues the first RAM read. The counter runs
    // down to zero inside GAP, so it is loaded with GAP_CYC-3.
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(GAP_CYC - 3);

    // ---------------- write side ----------------
    wr_state_t          r_wr_state;
    logic [ADDR_W:0]    r_wr_ptr;
    logic [ADDR_W:0]    r_frm_start;
    logic [ADDR_W-1:0]  r_wr_cnt;
    logic               r_rdy_en;
    logic [15:0]        r_stat_dropped;

    // ---------------- length FIFO ----------------
    logic [ADDR_W-1:0]  r_len_mem [0:(1<<LEN_W)-1];
    logic [LEN_W:0]     r_len_wp;
    logic [LEN_W:0]     r_len_rp;

    // ---------------- read side ----------------
    tx_state_t          r_state;
    tx_state_t          w_state_nxt;
    logic [ADDR_W:0]    r_rd_ptr;
    logic [ADDR_W-1:0]  r_rd_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [15:0]        r_stat_sent;

    logic               w_byte_full;
    logic               w_len_full;
    logic               w_len_empty;
    logic               w_wr_fire;
    logic               w_wr_acc;
    logic               w_commit;
    logic               w_overflow;
    logic [ADDR_W-1:0]  w_cnt_nxt;
    logic [ADDR_W:0]    w_frm_base;
    logic [ADDR_W-1:0]  w_len_head;
    logic               w_launch;
    logic               w_last_data;
    logic               w_eof;
    logic               w_rd_adv;
    logic [7:0]         w_ram_rdata;

    // Occupancy flags: extra MSB distinguishes full from empty
    assign w_byte_full = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                         (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_len_full  = (r_len_wp[LEN_W] != r_len_rp[LEN_W]) &&
                         (r_len_wp[LEN_W-1:0] == r_len_rp[LEN_W-1:0]);
    assign w_len_empty = (r_len_wp == r_len_rp);

    // Upstream handshake; r_rdy_en keeps s_ready low until the first
    // clock after reset release
    assign s_ready   = r_rdy_en & ((r_wr_state == DISCARD) | (~w_byte_full & ~w_len_full));
    assign w_wr_fire = s_valid & s_ready;
    assign w_wr_acc  = w_wr_fire & (r_wr_state == ACCEPT);
    assign w_cnt_nxt = r_wr_cnt + 1'b1;
    assign w_commit  = w_wr_acc & s_last;
    assign w_overflow = w_wr_acc & ~s_last & (w_cnt_nxt == c_MAX_LEN);
    assign w_frm_base = (r_wr_cnt == '0) ? r_wr_ptr : r_frm_start;

    // Write-side pointer, length counter, discard state and drop counter
    always_ff @(posedge mac_tx_clk or negedge mac_tx_rst_n) begin
        if (!mac_tx_rst_n) begin
            r_wr_state     <= ACCEPT;
            r_wr_ptr       <= '0;
            r_frm_start    <= '0;
            r_wr_cnt       <= '0;
            r_rdy_en       <= 1'b0;
            r_stat_dropped <= '0;
            r_len_wp       <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_wr_acc) begin
                if (r_wr_cnt == '0) begin
                    r_frm_start <= r_wr_ptr;
                end
                if (w_commit) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_wr_cnt <= '0;
                    r_len_wp <= r_len_wp + 1'b1;
                end else if (w_overflow) begin
                    // Oversize: forget everything written for this frame
                    r_wr_state <= DISCARD;
                    r_wr_ptr   <= w_frm_base;
                    r_wr_cnt   <= '0;
                end else begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_wr_cnt <= w_cnt_nxt;
                end
            end else if (w_wr_fire && s_last) begin
                r_wr_state     <= ACCEPT;
                r_stat_dropped <= r_stat_dropped + 1'b1;
            end
        end
    end

    // Length FIFO storage, written on each frame commit
    always_ff @(posedge mac_tx_clk) begin
        if (w_commit) begin
            r_len_mem[r_len_wp[LEN_W-1:0]] <= w_cnt_nxt;
        end
    end

    mac_tx_fifo_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (mac_tx_clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (s_data),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_ram_rdata)
    );

    assign w_len_head  = r_len_mem[r_len_rp[LEN_W-1:0]];
    assign w_launch    = (r_state == IDLE) & ~w_len_empty & (r_gap_cnt == '0);
    assign w_last_data = (r_state == SEND) & (r_rd_cnt == (w_len_head - 1'b1));
    assign w_eof       = (w_last_data & (w_len_head >= c_MIN_LEN)) |
                         ((r_state == PAD) & (r_rd_cnt == c_PAD_LAST));
    // Prefetch: one read ahead of the byte currently on the output
    assign w_rd_adv    = w_launch | ((r_state == SEND) & ~w_last_data);

    // Read FSM next-state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_launch) w_state_nxt = SEND;
            SEND: if (w_last_data) w_state_nxt = (w_len_head < c_MIN_LEN) ? PAD : GAP;
            PAD:  if (w_eof) w_state_nxt = GAP;
            GAP:  if (r_gap_cnt == '0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Read FSM state, pointer, byte count, gap timer and sent counter
    always_ff @(posedge mac_tx_clk or negedge mac_tx_rst_n) begin
        if (!mac_tx_rst_n) begin
            r_state     <= IDLE;
            r_rd_ptr    <= '0;
            r_rd_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_stat_sent <= '0;
            r_len_rp    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_launch || w_eof) begin
                r_rd_cnt <= '0;
            end else if (mac_tx_valid) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (w_eof) begin
                r_gap_cnt   <= c_GAP_LOAD;
                r_stat_sent <= r_stat_sent + 1'b1;
            end else if ((r_state == GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
            if (w_last_data) begin
                r_len_rp <= r_len_rp + 1'b1;
            end
        end
    end

    assign mac_tx_valid = (r_state == SEND) | (r_state == PAD);
    assign mac_tx_data  = (r_state == SEND) ? w_ram_rdata : 8'h00;
    assign mac_tx_sof   = (r_state == SEND) & (r_rd_cnt == '0);
    assign mac_tx_eof   = w_eof;
    assign busy         = (r_state != IDLE) | ~w_len_empty;
    assign stat_sent    = r_stat_sent;
    assign stat_dropped = r_stat_dropped;

endmodule : mac_tx_frame_src
`default_nettype wire
